// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU/M-extension encodings for the execute-stage decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_t;

    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M/RV64M multiply/divide engine with start/done handshake.
// ALU_DEC_FASTMUL_EN: multiply in one cycle with an array multiplier instead of shift-add.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  md_op_t          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            idle_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] p_q;
    logic [XLEN-1:0]   m_q;
    logic [XLEN-1:0]   result_q;
    logic              sa_q, sb_q, rem_q;

    logic              is_div, a_signed, b_signed, sa, sb, div_zero, ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic [XLEN:0]     div_sh, div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo, rem, div_res;

    // Select the high or low half of a magnitude product after restoring its sign.
    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p, input logic neg, input logic hi);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return hi ? s[2*XLEN-1:XLEN] : s[XLEN-1:0];
    endfunction

    assign is_div      = op_i[2];
    assign a_signed    = op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    assign b_signed    = op_i inside {MD_MULH, MD_DIV, MD_REM};
    assign sa          = a_signed & a_i[XLEN-1];
    assign sb          = b_signed & b_i[XLEN-1];
    assign mag_a       = sa ? -a_i : a_i;
    assign mag_b       = sb ? -b_i : b_i;
    assign div_zero    = is_div & (b_i == '0);
    assign ovf         = (op_i == MD_DIV || op_i == MD_REM) && a_i == MIN_NEG && b_i == '1;
    // op_i[1] separates REM/REMU from DIV/DIVU
    assign special_res = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);

    // Restoring divide step: remainder in the upper half, dividend/quotient in the lower half.
    assign div_sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, m_q};
    assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    assign quo      = div_next[XLEN-1:0];
    assign rem      = div_next[2*XLEN-1:XLEN];
    assign div_res  = rem_q ? (sa_q ? -rem : rem) : ((sa_q ^ sb_q) ? -quo : quo);

`ifndef ALU_DEC_FASTMUL_EN
    logic              hi_q;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    // Shift-add step: add the multiplicand into the upper half when the low bit is set, then shift right.
    assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, p_q[XLEN-1:1]};
`endif

    // Engine FSM: latch operands, iterate one bit per cycle, fix signs on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            rem_q    <= 1'b0;
`ifndef ALU_DEC_FASTMUL_EN
            hi_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    sa_q  <= sa;
                    sb_q  <= sb;
                    rem_q <= op_i[1];
                    cnt_q <= CW'(XLEN-1);
                    if (div_zero || ovf) begin
                        result_q <= special_res;
                        state_q  <= S_DONE;
                    end else if (is_div) begin
                        p_q     <= {{XLEN{1'b0}}, mag_a};
                        m_q     <= mag_b;
                        state_q <= S_DIV;
                    end else begin
`ifdef ALU_DEC_FASTMUL_EN
                        result_q <= mul_pick({{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b}, sa ^ sb, |op_i[1:0]);
                        state_q  <= S_DONE;
`else
                        hi_q    <= |op_i[1:0];
                        p_q     <= {{XLEN{1'b0}}, mag_b};
                        m_q     <= mag_a;
                        state_q <= S_MUL;
`endif
                    end
                end
`ifndef ALU_DEC_FASTMUL_EN
                S_MUL: begin
                    p_q   <= mul_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        result_q <= mul_pick(mul_next, sa_q ^ sb_q, hi_q);
                        state_q  <= S_DONE;
                    end
                end
`endif
                S_DIV: begin
                    p_q   <= div_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        result_q <= div_res;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign idle_o   = state_q == S_IDLE;
    assign busy_o   = state_q == S_MUL || state_q == S_DIV;
    assign done_o   = state_q == S_DONE;
    assign result_o = result_q;

endmodule

// File: rtl/alu_decoder_md.sv
// alu_decoder_md: ALUOp/funct3/funct7 decoder with RV32M/RV64M multiply/divide and pipeline stall.
// ALU_DEC_FASTMUL_EN: selects the single-cycle multiplier inside muldiv_iter.
module alu_decoder_md
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [3:0]      alu_op,
    output logic            use_md,
    output logic            stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    logic    req, alt, idle, busy;
    alu_op_t rtype_op;

    assign req = valid_i && ALUOp == 2'b10 && funct7 == FUNCT7_MEXT;
    assign alt = funct7 == FUNCT7_ALT;

    // R/I-type operation by funct3; funct7 alt bit picks SUB and SRA.
    always_comb begin
        rtype_op = ALU_ADD;
        case (funct3)
            3'b000: rtype_op = alt ? ALU_SUB : ALU_ADD;
            3'b001: rtype_op = ALU_SLL;
            3'b010: rtype_op = ALU_SLT;
            3'b011: rtype_op = ALU_SLTU;
            3'b100: rtype_op = ALU_XOR;
            3'b101: rtype_op = alt ? ALU_SRA : ALU_SRL;
            3'b110: rtype_op = ALU_OR;
            3'b111: rtype_op = ALU_AND;
        endcase
    end

    assign alu_op = req            ? ALU_ADD :
                    ALUOp == 2'b00 ? ALU_ADD :
                    ALUOp == 2'b01 ? ALU_SUB :
                    ALUOp == 2'b11 ? ALU_LUI : rtype_op;
    assign use_md = req;
    // The pipeline is released in the DONE cycle, so only a fresh request or an active iteration stalls.
    assign stall  = !rst && ((idle && req) || busy);

    muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk      (clk),
        .rst      (rst),
        .start_i  (req),
        .op_i     (md_op_t'(funct3)),
        .a_i      (rs1_val),
        .b_i      (rs2_val),
        .idle_o   (idle),
        .busy_o   (busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

endmodule

// File: tb/tb_alu_decoder_md.sv
// tb_alu_decoder_md: directed self-checking bench for alu_decoder_md (XLEN=32).
module tb_alu_decoder_md;

`ifdef ALU_DEC_FASTMUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst, valid_i;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val, rs2_val;
    logic [3:0]  alu_op;
    logic        use_md, stall, md_done;
    logic [31:0] md_result;

    int n_cmp = 0;
    int n_fail = 0;

    alu_decoder_md #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ALUOp     (ALUOp),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .alu_op    (alu_op),
        .use_md    (use_md),
        .stall     (stall),
        .md_done   (md_done),
        .md_result (md_result)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b1; ALUOp = 2'b10; funct3 = 3'b100; funct7 = 7'b0000001;
        rs1_val = 32'd9; rs2_val = 32'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        n_cmp++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", md_done); end
        n_cmp++; if (md_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", md_result); end
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall got %b want 0", stall); end
        n_cmp++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL post_reset_done got %b want 0", md_done); end
    endtask

    task automatic test_decode();
        logic [15:0] vec [14];
        logic [15:0] v;
        // {ALUOp, funct3, funct7, expected alu_op}
        vec[0]  = {2'b00, 3'b000, 7'b0000000, 4'd0};
        vec[1]  = {2'b01, 3'b000, 7'b0000000, 4'd1};
        vec[2]  = {2'b11, 3'b000, 7'b0000000, 4'd10};
        vec[3]  = {2'b10, 3'b000, 7'b0000000, 4'd0};
        vec[4]  = {2'b10, 3'b000, 7'b0100000, 4'd1};
        vec[5]  = {2'b10, 3'b001, 7'b0000000, 4'd2};
        vec[6]  = {2'b10, 3'b010, 7'b0000000, 4'd3};
        vec[7]  = {2'b10, 3'b011, 7'b0000000, 4'd4};
        vec[8]  = {2'b10, 3'b100, 7'b0000000, 4'd5};
        vec[9]  = {2'b10, 3'b101, 7'b0000000, 4'd6};
        vec[10] = {2'b10, 3'b101, 7'b0100000, 4'd7};
        vec[11] = {2'b10, 3'b110, 7'b0000000, 4'd8};
        vec[12] = {2'b10, 3'b111, 7'b0000000, 4'd9};
        vec[13] = {2'b00, 3'b101, 7'b0100000, 4'd0};
        @(posedge clk); #1;
        valid_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            v = vec[i];
            ALUOp = v[15:14]; funct3 = v[13:11]; funct7 = v[10:4];
            #1;
            n_cmp++; if (alu_op !== v[3:0]) begin n_fail++; $display("FAIL decode[%0d] alu_op got %0d want %0d", i, alu_op, v[3:0]); end
            n_cmp++; if (use_md !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL decode[%0d] use_md/stall got %b%b want 00", i, use_md, stall); end
        end
        valid_i = 1'b0; ALUOp = 2'b10; funct3 = 3'b100; funct7 = 7'b0000001;
        #1;
        n_cmp++; if (use_md !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL decode_invalid_m use_md/stall got %b%b want 00", use_md, stall); end
    endtask

    task automatic run_md(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int stalls;
        lat = -1; stalls = 0;
        @(posedge clk); #1;
        valid_i = 1'b1; ALUOp = 2'b10; funct3 = f3; funct7 = 7'b0000001; rs1_val = a; rs2_val = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_cmp++; if (use_md !== 1'b1 || alu_op !== 4'd0) begin n_fail++; $display("FAIL %s decode use_md/alu_op got %b/%0d want 1/0", name, use_md, alu_op); end
            end
            if (md_done === 1'b1) begin lat = k; break; end
            if (stall === 1'b1) stalls++;
        end
        n_cmp++; if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
        n_cmp++; if (stalls != exp_lat) begin n_fail++; $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, exp_lat); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s stall_in_done got %b want 0", name, stall); end
        n_cmp++; if (md_result !== exp_res) begin n_fail++; $display("FAIL %s result got %h want %h", name, md_result, exp_res); end
    endtask

    task automatic release_bus(input string name, input logic [31:0] exp_res);
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse got %b want 0", name, md_done); end
        n_cmp++; if (md_result !== exp_res) begin n_fail++; $display("FAIL %s result_hold got %h want %h", name, md_result, exp_res); end
    endtask

    task automatic test_mul();
        run_md("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        release_bus("mul", 32'hFFFFFFEB);
        run_md("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        release_bus("mulhu", 32'hFFFFFFFE);
        run_md("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
        run_md("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
        release_bus("mulhsu", 32'hFFFFFFFF);
    endtask

    task automatic test_div();
        run_md("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT);
        run_md("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DIV_LAT);
        run_md("divu", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        release_bus("divu", 32'd14);
    endtask

    task automatic test_div_special();
        run_md("divu_zero", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_md("rem_zero", 3'b110, 32'd5, 32'd0, 32'd5, 1);
        run_md("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_md("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        release_bus("rem_ovf", 32'h00000000);
    endtask

    task automatic test_reset_mid();
        run_md("pre_rst", 3'b101, 32'd50, 32'd3, 32'd16, DIV_LAT);
        @(posedge clk); #1;
        funct3 = 3'b100; rs1_val = 32'hFFFFFFF9; rs2_val = 32'd2;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst stall_masked got %b want 0", stall); end
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst stall got %b want 0", stall); end
        n_cmp++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst done got %b want 0", md_done); end
        n_cmp++; if (md_result !== 32'd0) begin n_fail++; $display("FAIL mid_rst result got %h want 0", md_result); end
        run_md("post_rst", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        release_bus("post_rst", 32'd14);
    endtask

    task automatic test_back_to_back();
        run_md("b2b_mul", 3'b000, 32'd3, 32'd5, 32'd15, MUL_LAT);
        run_md("b2b_remu", 3'b111, 32'd17, 32'd5, 32'd2, DIV_LAT);
        run_md("b2b_divu0", 3'b101, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
        release_bus("b2b", 32'hFFFFFFFF);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul();
        test_div();
        test_div_special();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
